// File: rtl/patgen_pkg.sv
// Shared types and constants for the AXI4-Stream pattern generator.
// Optional PATGEN_THROTTLE_EN build adds inter-beat gaps in axis_pattern_gen.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam logic MODE_INCR = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // First incrementing beat: byte j = base + j.
  function automatic logic [63:0] incr_first(input logic [7:0] base);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = base + 8'(j);
    return d;
  endfunction

  // Next incrementing beat: every byte advances by 8, wrapping per byte.
  function automatic logic [63:0] incr_step(input logic [63:0] d);
    logic [63:0] n;
    for (int j = 0; j < 8; j++) n[8*j +: 8] = d[8*j +: 8] + 8'd8;
    return n;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 64'h0);
  endfunction

endpackage

// File: rtl/byte_sum8.sv
// Signed 8-bit sum of the eight bytes of a 64-bit word; every tree stage wraps mod 256.
module byte_sum8 (
  input  logic [63:0]       data,
  output logic signed [7:0] sum
);

  logic [7:0] s01, s23, s45, s67, s0123, s4567;

  assign s01   = data[7:0]   + data[15:8];
  assign s23   = data[23:16] + data[31:24];
  assign s45   = data[39:32] + data[47:40];
  assign s67   = data[55:48] + data[63:56];
  assign s0123 = s01 + s23;
  assign s4567 = s45 + s67;
  assign sum   = s0123 + s4567;

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream burst pattern generator (incrementing bytes or 64-bit LFSR) with a running
// expected byte-sum. Define PATGEN_THROTTLE_EN to add the gap input for inter-beat idle cycles.
module axis_pattern_gen
  import patgen_pkg::*;
#(
  parameter int B     = 64,
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [B-1:0]     seed,
  input  logic             mode,
`ifdef PATGEN_THROTTLE_EN
  input  logic [7:0]       gap,
`endif
  output logic             m_axis_tvalid,
  output logic [B-1:0]     m_axis_tdata,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] beat_cnt,
  output logic [31:0]      exp_sum
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic             mode_q;
  logic [B-1:0]     pat_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [31:0]      exp_sum_q;
  logic             gap_clear;
  logic             hs;
  logic             last_beat;
  logic             accept;
  logic signed [7:0] bsum;

  byte_sum8 u_sum (
    .data(pat_q),
    .sum (bsum)
  );

  assign hs        = m_axis_tvalid & m_axis_tready;
  assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));
  assign accept    = (state_q == IDLE) & start;

`ifdef PATGEN_THROTTLE_EN
  logic [7:0] gap_q, gap_cnt_q;

  assign gap_clear = (gap_cnt_q == 8'd0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      gap_q     <= '0;
      gap_cnt_q <= '0;
    end else if (accept) begin
      gap_q     <= gap;
      gap_cnt_q <= '0;
    end else if (hs) begin
      gap_cnt_q <= last_beat ? 8'd0 : gap_q;
    end else if (!gap_clear) begin
      gap_cnt_q <= gap_cnt_q - 8'd1;
    end
  end
`else
  assign gap_clear = 1'b1;
`endif

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (len == '0) ? DONE : RUN;
      RUN: begin
        busy          = 1'b1;
        m_axis_tvalid = gap_clear;
        m_axis_tlast  = gap_clear & last_beat;
        if (hs && last_beat) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      len_q      <= '0;
      mode_q     <= MODE_INCR;
      pat_q      <= '0;
      beat_cnt_q <= '0;
      exp_sum_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q      <= len;
        mode_q     <= mode;
        beat_cnt_q <= '0;
        exp_sum_q  <= '0;
        if (mode == MODE_LFSR) pat_q <= (seed == '0) ? B'(1) : seed;
        else                   pat_q <= incr_first(seed[7:0]);
      end else if (hs) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
        exp_sum_q  <= exp_sum_q + {{24{bsum[7]}}, bsum};
        pat_q      <= (mode_q == MODE_LFSR) ? lfsr_step(pat_q) : incr_step(pat_q);
      end
    end
  end

  assign m_axis_tdata = pat_q;
  assign beat_cnt     = beat_cnt_q;
  assign exp_sum      = exp_sum_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen: vector table of bursts, beat scoreboard, corner sequences.
module tb_axis_pattern_gen;

  localparam int B     = 64;
  localparam int LEN_W = 32;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [B-1:0]     seed = '0;
  logic             mode = 1'b0;
  logic [7:0]       gap = '0;
  logic             tready = 1'b1;
  logic             tvalid, tlast, busy, done;
  logic [B-1:0]     tdata;
  logic [LEN_W-1:0] beat_cnt;
  logic [31:0]      exp_sum;

  always #5 clk = ~clk;

  axis_pattern_gen #(.B(B), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .len          (len),
    .seed         (seed),
    .mode         (mode),
`ifdef PATGEN_THROTTLE_EN
    .gap          (gap),
`endif
    .m_axis_tvalid(tvalid),
    .m_axis_tdata (tdata),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .busy         (busy),
    .done         (done),
    .beat_cnt     (beat_cnt),
    .exp_sum      (exp_sum)
  );

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        mode;
    logic [63:0] seed;
    int          len;
    logic [7:0]  gap;
    int          rdy;      // 0 = always ready, 1 = random, 2 = long stalls
    logic [31:0] exp_sum;
  } vec_t;

  beat_t      sb[$];
  int         n_checks = 0;
  int         n_err = 0;
  int         rdy_mode = 0;
  int         stall_left = 0;
  int         hs_count = 0;
  int         idle_obs = 0;
  logic [7:0] cur_gap = '0;
  logic       prev_v = 0, prev_r = 0, prev_l = 0, prev_rst = 0;
  logic [63:0] prev_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_incr(input logic [7:0] base, input int k);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(int'(base) + 8 * k + j);
    return d;
  endfunction

  function automatic logic [63:0] m_lfsr(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [63:0] m_beat(input logic m, input logic [63:0] s, input int k);
    logic [63:0] st;
    st = (s == 64'h0) ? 64'h1 : s;
    if (!m) return m_incr(s[7:0], k);
    for (int i = 0; i < k; i++) st = m_lfsr(st);
    return st;
  endfunction

  function automatic logic [31:0] m_sum(input logic m, input logic [63:0] s, input int n);
    logic [31:0]      acc;
    logic [63:0]      d;
    logic signed [7:0] b8;
    int               bs;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      d  = m_beat(m, s, k);
      bs = 0;
      for (int j = 0; j < 8; j++) bs += $signed(d[8*j +: 8]);
      b8  = bs[7:0];
      acc = acc + {{24{b8[7]}}, b8};
    end
    return acc;
  endfunction

  // Ready generator: changes tready just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: tready = 1'b1;
      1: tready = 1'($urandom_range(0, 1));
      default: begin
        if (stall_left > 0) begin
          tready = 1'b0;
          stall_left--;
        end else if ($urandom_range(0, 3) == 0) begin
          stall_left = int'($urandom_range(3, 12));
          tready = 1'b0;
        end else begin
          tready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: on the falling edge, a beat with tvalid & tready completes at the next rising edge.
  always @(negedge clk) begin
    beat_t e;
    if (rstn && prev_rst && prev_v && !prev_r) begin
      check("hold_tvalid", 64'(tvalid), 64'h1);
      check("hold_tdata", tdata, prev_d);
      check("hold_tlast", 64'(tlast), 64'(prev_l));
    end
    if (rstn && tvalid && tready) begin
      check("beat_expected", 64'(sb.size() != 0), 64'h1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("tdata", tdata, e.data);
        check("tlast", 64'(tlast), 64'(e.last));
      end
      if (rdy_mode == 0 && hs_count > 0) check("gap_cycles", 64'(idle_obs), 64'(cur_gap));
      hs_count++;
      idle_obs = 0;
    end else if (rstn && busy && !tvalid) begin
      idle_obs++;
    end
    prev_v   = tvalid;
    prev_r   = tready;
    prev_d   = tdata;
    prev_l   = tlast;
    prev_rst = rstn;
  end

  task automatic launch(input logic m, input logic [63:0] s, input int n, input logic [7:0] g);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = m;
    seed  = s;
    len   = LEN_W'(n);
    gap   = g;
`ifdef PATGEN_THROTTLE_EN
    cur_gap = g;
`else
    cur_gap = 8'd0;
`endif
    hs_count = 0;
    idle_obs = 0;
    for (int k = 0; k < n; k++) sb.push_back('{data: m_beat(m, s, k), last: (k == n - 1)});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish(input string name, input logic [31:0] es, input int n);
    int t;
    bit seen;
    t = 0;
    seen = 0;
    while (!seen && t < n * 40 + 200) begin
      @(negedge clk);
      t++;
      if (done) seen = 1;
    end
    check({name, "_done_seen"}, 64'(seen), 64'h1);
    if (seen) begin
      check({name, "_exp_sum"}, 64'(exp_sum), 64'(es));
      check({name, "_beat_cnt"}, 64'(beat_cnt), 64'(n));
      check({name, "_handshakes"}, 64'(hs_count), 64'(n));
      check({name, "_sb_drained"}, 64'(sb.size()), 64'h0);
      check({name, "_busy_in_done"}, 64'(busy), 64'h0);
      @(negedge clk);
      check({name, "_done_one_cycle"}, 64'(done), 64'h0);
      check({name, "_sum_held"}, 64'(exp_sum), 64'(es));
    end
    sb.delete();
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_tvalid"}, 64'(tvalid), 64'h0);
    check({name, "_tlast"}, 64'(tlast), 64'h0);
    check({name, "_tdata"}, tdata, 64'h0);
    check({name, "_busy"}, 64'(busy), 64'h0);
    check({name, "_done"}, 64'(done), 64'h0);
    check({name, "_beat_cnt"}, 64'(beat_cnt), 64'h0);
    check({name, "_exp_sum"}, 64'(exp_sum), 64'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[7];
    logic [63:0] rs;
    int          t;
    int          dn;

    rs = {$urandom, $urandom};
    tbl[0] = '{1'b0, 64'h0, 1, 8'd0, 0, 32'd28};
    tbl[1] = '{1'b0, 64'h0, 32, 8'd0, 0, 32'hFFFF_FF80};
    tbl[2] = '{1'b1, 64'h0, 3, 8'd0, 0, m_sum(1'b1, 64'h0, 3)};
    tbl[3] = '{1'b0, 64'hF3, 4, 8'd0, 2, m_sum(1'b0, 64'hF3, 4)};
    tbl[4] = '{1'b1, rs, 20, 8'd0, 1, m_sum(1'b1, rs, 20)};
    tbl[5] = '{1'b0, 64'hA5, 6, 8'd3, 0, m_sum(1'b0, 64'hA5, 6)};
    tbl[6] = '{1'b1, 64'h0123_4567_89AB_CDEF, 12, 8'd1, 2, m_sum(1'b1, 64'h0123_4567_89AB_CDEF, 12)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      rdy_mode = tbl[i].rdy;
      launch(tbl[i].mode, tbl[i].seed, tbl[i].len, tbl[i].gap);
      finish($sformatf("vec%0d", i), tbl[i].exp_sum, tbl[i].len);
      rdy_mode = 0;
    end

    // Zero-length burst: straight to DONE, no beats.
    launch(1'b0, 64'h0, 0, 8'd0);
    finish("len0", 32'h0, 0);

    // start while RUN must not restart or resize the burst.
    launch(1'b0, 64'h10, 6, 8'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = LEN_W'(2);
    mode  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish("start_in_run", m_sum(1'b0, 64'h10, 6), 6);

    // Reset at beat 2 of an 8-beat burst, with a start pulse under reset.
    launch(1'b0, 64'h0, 8, 8'd0);
    t = 0;
    while (hs_count < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("rst_reached_beat2", 64'(hs_count), 64'h2);
    #1;
    rstn  = 1'b0;
    start = 1'b1;
    len   = LEN_W'(5);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_idle_zero("mid_rst");
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      dn += int'(done) + int'(busy);
    end
    check("mid_rst_no_activity", 64'(dn), 64'h0);
    sb.delete();

    rdy_mode = 2;
    launch(1'b1, 64'hDEAD_BEEF_0000_0001, 10, 8'd2);
    finish("after_rst", m_sum(1'b1, 64'hDEAD_BEEF_0000_0001, 10), 10);
    rdy_mode = 0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
